// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces whole
// scan frames and hands each new press to user logic through a one-deep valid/ack buffer.
module keypad4x4_scan #(
  parameter int SCAN_DIV_W      = 15,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [3:0]  o_col,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_key_code,
  output logic        o_key_valid,
  input  logic        i_key_ack,
  output logic        o_overrun,
  output logic        o_key_down,
  output logic [15:0] o_key_bitmap
);

  localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE_FRAMES);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [3:0]            row_meta_reg;
  logic [3:0]            row_sync_reg;
  logic [SCAN_DIV_W-1:0] cnt_reg;
  logic [1:0]            col_addr_reg;
  logic [15:0]           raw_reg;
  logic [15:0]           last_frame_reg;
  logic [15:0]           bitmap_reg;
  logic [3:0]            run_reg;
  state_t                state_reg;
  logic                  valid_reg;
  logic [3:0]            code_reg;
  logic                  overrun_reg;

  logic                  tick;
  logic                  frame_done;
  logic [15:0]           frame;
  logic [3:0]            run_next;
  logic                  commit;
  logic [15:0]           new_keys;
  logic                  press_event;
  logic [3:0]            press_code;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= i_row;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign tick       = &cnt_reg;
  assign frame_done = tick && (col_addr_reg == 2'd3);
  assign o_col      = ~(4'b0001 << col_addr_reg);

  // Rows are captured at the end of each column period so the strobe has a full tick to settle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg      <= '0;
      col_addr_reg <= 2'd0;
      raw_reg      <= 16'h0000;
    end else begin
      cnt_reg <= cnt_reg + SCAN_DIV_W'(1);
      if (tick) begin
        for (int c = 0; c < 4; c++) begin
          if (col_addr_reg == 2'(c)) raw_reg[c*4 +: 4] <= ~row_sync_reg;
        end
        col_addr_reg <= col_addr_reg + 2'd1;
      end
    end
  end

  // The last column of a frame is taken live so the frame is judged on the completing tick.
  always_comb begin
    frame         = raw_reg;
    frame[15:12]  = ~row_sync_reg;
  end

  always_comb begin
    if (frame == last_frame_reg) begin
      run_next = (run_reg >= RUN_MAX) ? RUN_MAX : run_reg + 4'd1;
    end else begin
      run_next = 4'd1;
    end
  end

  assign commit      = frame_done && (run_next == RUN_MAX);
  assign new_keys    = frame & ~bitmap_reg;
  assign press_event = commit && (new_keys != 16'h0000);

  // Lowest newly pressed index wins; the others only show up in the bitmap.
  always_comb begin
    press_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_keys[i]) press_code = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_reg        <= 4'd0;
      last_frame_reg <= 16'h0000;
      bitmap_reg     <= 16'h0000;
    end else if (frame_done) begin
      run_reg        <= run_next;
      last_frame_reg <= frame;
      if (run_next == RUN_MAX) bitmap_reg <= frame;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      code_reg    <= 4'd0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press_event) begin
            code_reg  <= press_code;
            valid_reg <= 1'b1;
            state_reg <= PENDING;
          end
        end
        PENDING: begin
          if (i_key_ack) begin
            overrun_reg <= 1'b0;
            if (press_event) begin
              code_reg <= press_code;
            end else begin
              valid_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end else if (press_event) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_key_valid  = valid_reg;
  assign o_key_code   = code_reg;
  assign o_overrun    = overrun_reg;
  assign o_key_bitmap = bitmap_reg;
  assign o_key_down   = |bitmap_reg;

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Bench for keypad4x4_scan: keypad pin model, frame-level reference model and scenario tasks.
module tb_keypad4x4_scan;

  localparam int DIV_W = 4;
  localparam int DBF   = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  o_col;
  logic [3:0]  i_row;
  logic [3:0]  o_key_code;
  logic        o_key_valid;
  logic        i_key_ack = 1'b0;
  logic        o_overrun;
  logic        o_key_down;
  logic [15:0] o_key_bitmap;
  logic [15:0] held = 16'h0000;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad4x4_scan #(.SCAN_DIV_W(DIV_W), .DEBOUNCE_FRAMES(DBF)) dut (
    .clk(clk), .rstn(rstn), .o_col(o_col), .i_row(i_row),
    .o_key_code(o_key_code), .o_key_valid(o_key_valid), .i_key_ack(i_key_ack),
    .o_overrun(o_overrun), .o_key_down(o_key_down), .o_key_bitmap(o_key_bitmap)
  );

  // Keypad matrix: a held key shorts its row low while its column is strobed.
  always_comb begin
    i_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (held[c*4+r] && !o_col[c]) i_row[r] = 1'b0;
  end

  // Reference model state, stepped once per clock edge.
  int unsigned m_k = 0;
  logic [15:0] hd1 = 0, hd2 = 0, m_raw = 0, m_bm = 0;
  logic [15:0] m_frames [DBF];
  int          m_nframes = 0;
  logic        m_valid = 0, m_overrun = 0;
  logic [3:0]  m_code = 0;

  task automatic run_model();
    logic [15:0] frame, newk;
    int col;
    bit stable, ev;
    logic [3:0] evc;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_k = 0; hd1 = 0; hd2 = 0; m_raw = 0; m_bm = 0; m_nframes = 0;
        m_valid = 0; m_code = 0; m_overrun = 0;
      end else begin
        ev = 0; evc = 0;
        if (m_k % 16 == 15) begin
          col = (m_k / 16) % 4;
          m_raw[col*4 +: 4] = hd2[col*4 +: 4];
          if (col == 3) begin
            frame = m_raw;
            for (int i = DBF-1; i > 0; i--) m_frames[i] = m_frames[i-1];
            m_frames[0] = frame;
            m_nframes++;
            stable = (m_nframes >= DBF);
            for (int i = 0; i < DBF; i++) if (m_frames[i] != frame) stable = 0;
            if (stable) begin
              newk = frame & ~m_bm;
              m_bm = frame;
              for (int i = 0; i < 16; i++) if (newk[i] && !ev) begin ev = 1; evc = 4'(i); end
            end
          end
        end
        if (!m_valid) begin
          if (ev) begin m_valid = 1; m_code = evc; end
        end else if (i_key_ack) begin
          m_overrun = 0;
          if (ev) m_code = evc; else m_valid = 0;
        end else if (ev) begin
          m_overrun = 1;
        end
        hd2 = hd1; hd1 = held; m_k++;
      end
    end
  endtask

  task automatic monitor_model();
    int shown = 0;
    logic [3:0] ec;
    forever begin
      @(posedge clk); #2;
      if (rstn && shown < 8) begin
        ec = 4'b1111;
        ec[(m_k/16)%4] = 1'b0;
        total++;
        if (o_key_valid !== m_valid || o_key_code !== m_code || o_overrun !== m_overrun ||
            o_key_bitmap !== m_bm || o_key_down !== (|m_bm) || o_col !== ec) begin
          bad++; shown++;
          $display("FAIL monitor t=%0t valid=%b/%b code=%h/%h ovr=%b/%b bitmap=%h/%h col=%b/%b (got/want)",
                   $time, o_key_valid, m_valid, o_key_code, m_code, o_overrun, m_overrun,
                   o_key_bitmap, m_bm, o_col, ec);
        end
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen, output int cyc);
    seen = 0; cyc = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (o_key_valid === 1'b1) seen = 1;
    end
  endtask

  task automatic ack_pulse();
    i_key_ack = 1'b1;
    @(negedge clk);
    i_key_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 0; held = 0; i_key_ack = 0;
    repeat (3) @(negedge clk);
    total++; if (o_col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", o_col); end
    total++; if (o_key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_key_valid); end
    total++; if (o_key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", o_key_code); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", o_overrun); end
    total++; if (o_key_down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b want=0", o_key_down); end
    total++; if (o_key_bitmap !== 16'h0) begin bad++; $display("FAIL reset_bitmap got=%h want=0000", o_key_bitmap); end
    rstn = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_press();
    bit seen, quiet; int cyc;
    held = 16'h0040;
    wait_valid(259, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL single_latency got=none_in_%0d want<=259clk", cyc); end
    total++; if (o_key_code !== 4'h6) begin bad++; $display("FAIL single_code got=%h want=6", o_key_code); end
    total++; if (o_key_bitmap !== 16'h0040) begin bad++; $display("FAIL single_bitmap got=%h want=0040", o_key_bitmap); end
    total++; if (o_key_down !== 1'b1) begin bad++; $display("FAIL single_down got=%b want=1", o_key_down); end
    ack_pulse();
    total++; if (o_key_valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%b want=0", o_key_valid); end
    held = 0; quiet = 1;
    repeat (260) begin @(negedge clk); if (o_key_valid) quiet = 0; end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL single_release_valid got=valid want=none"); end
    total++; if (o_key_bitmap !== 16'h0) begin bad++; $display("FAIL single_release_bitmap got=%h want=0000", o_key_bitmap); end
    $display("single press: code=%h latency=%0d", 4'h6, cyc);
  endtask

  task automatic test_bounce();
    bit seen, quiet; int cyc;
    while (m_k % 64 != 20) @(negedge clk);
    quiet = 1;
    for (int i = 0; i < 300; i++) begin
      held = ((i / 40) % 2 == 0) ? 16'h0200 : 16'h0000;
      @(negedge clk);
      if (o_key_valid) quiet = 0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL bounce_window got=valid want=none"); end
    held = 16'h0200;
    wait_valid(300, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL bounce_valid got=none want=valid"); end
    total++; if (o_key_code !== 4'h9) begin bad++; $display("FAIL bounce_code got=%h want=9", o_key_code); end
    ack_pulse();
    quiet = 1;
    repeat (200) begin @(negedge clk); if (o_key_valid) quiet = 0; end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL bounce_second got=valid want=none"); end
    held = 0;
    repeat (260) @(negedge clk);
    $display("bounce: code=%h", 4'h9);
  endtask

  task automatic test_overrun();
    bit seen; int cyc;
    held = 16'h0040;
    wait_valid(300, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL overrun_first got=none want=valid"); end
    held = 0;
    repeat (260) @(negedge clk);
    held = 16'h0200;
    repeat (300) @(negedge clk);
    total++; if (o_key_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b want=1", o_key_valid); end
    total++; if (o_key_code !== 4'h6) begin bad++; $display("FAIL overrun_code got=%h want=6", o_key_code); end
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", o_overrun); end
    ack_pulse();
    total++; if (o_key_valid !== 1'b0) begin bad++; $display("FAIL overrun_ack_valid got=%b want=0", o_key_valid); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL overrun_ack_flag got=%b want=0", o_overrun); end
    held = 0;
    repeat (260) @(negedge clk);
    $display("overrun: kept code=%h", 4'h6);
  endtask

  task automatic test_ack_collision();
    bit seen; int cyc, guard;
    int unsigned target;
    held = 16'h0040;
    wait_valid(300, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL collide_first got=none want=valid"); end
    while (m_k % 64 != 0) @(negedge clk);
    held = 16'h1040;
    // Column 3 is sampled 63 edges into the frame; the third such frame commits.
    target = m_k + 191;
    guard = 0;
    while (m_k != target && guard < 400) begin @(negedge clk); guard++; end
    ack_pulse();
    total++; if (o_key_valid !== 1'b1) begin bad++; $display("FAIL collide_valid got=%b want=1", o_key_valid); end
    total++; if (o_key_code !== 4'hC) begin bad++; $display("FAIL collide_code got=%h want=c", o_key_code); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL collide_overrun got=%b want=0", o_overrun); end
    total++; if (o_key_bitmap !== 16'h1040) begin bad++; $display("FAIL collide_bitmap got=%h want=1040", o_key_bitmap); end
    ack_pulse();
    held = 0;
    repeat (260) @(negedge clk);
    $display("ack collision: code=%h", 4'hC);
  endtask

  task automatic test_multi_key();
    bit seen; int cyc;
    held = 16'h1008;
    wait_valid(400, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL multi_valid got=none want=valid"); end
    total++; if (o_key_code !== 4'h3) begin bad++; $display("FAIL multi_code got=%h want=3", o_key_code); end
    total++; if (o_key_bitmap !== 16'h1008) begin bad++; $display("FAIL multi_bitmap got=%h want=1008", o_key_bitmap); end
    ack_pulse();
    held = 0;
    repeat (260) @(negedge clk);
    $display("multi key: code=%h", 4'h3);
  endtask

  task automatic test_reset_mid();
    bit seen; int cyc;
    held = 16'h0040;
    wait_valid(300, seen, cyc);
    held = 0;
    repeat (260) @(negedge clk);
    held = 16'h0200;
    repeat (300) @(negedge clk);
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL rstmid_pre_overrun got=%b want=1", o_overrun); end
    rstn = 0;
    repeat (2) @(negedge clk);
    total++; if (o_key_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", o_key_valid); end
    total++; if (o_col !== 4'b1110) begin bad++; $display("FAIL rstmid_col got=%b want=1110", o_col); end
    total++; if (o_key_bitmap !== 16'h0) begin bad++; $display("FAIL rstmid_bitmap got=%h want=0000", o_key_bitmap); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b want=0", o_overrun); end
    rstn = 1;
    wait_valid(300, seen, cyc);
    total++; if (!seen) begin bad++; $display("FAIL rstmid_rereport got=none want=valid"); end
    total++; if (o_key_code !== 4'h9) begin bad++; $display("FAIL rstmid_code got=%h want=9", o_key_code); end
    ack_pulse();
    held = 0;
    repeat (260) @(negedge clk);
    $display("reset mid-pending: re-reported code=%h", 4'h9);
  endtask

  task automatic test_random();
    int hold, gap;
    for (int it = 0; it < 6; it++) begin
      held = 16'h0000;
      held[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) held[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(150, 400);
      for (int i = 0; i < hold; i++) begin
        i_key_ack = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      held = 0;
      gap = $urandom_range(150, 300);
      for (int i = 0; i < gap; i++) begin
        i_key_ack = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      i_key_ack = 0;
      @(negedge clk);
      total++; if (o_key_valid !== m_valid) begin bad++; $display("FAIL rand_valid it=%0d got=%b want=%b", it, o_key_valid, m_valid); end
      total++; if (o_key_code !== m_code) begin bad++; $display("FAIL rand_code it=%0d got=%h want=%h", it, o_key_code, m_code); end
      total++; if (o_overrun !== m_overrun) begin bad++; $display("FAIL rand_overrun it=%0d got=%b want=%b", it, o_overrun, m_overrun); end
      total++; if (o_key_bitmap !== m_bm) begin bad++; $display("FAIL rand_bitmap it=%0d got=%h want=%h", it, o_key_bitmap, m_bm); end
      $display("random %0d: hold=%0d gap=%0d valid=%b code=%h", it, hold, gap, o_key_valid, o_key_code);
    end
  endtask

  initial begin
    fork
      run_model();
      monitor_model();
    join_none
    test_reset();
    test_single_press();
    test_bounce();
    test_overrun();
    test_ack_collision();
    test_multi_key();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad4x4_scan.md
Name: keypad4x4_scan

Overview:
- 4x4 matrix keypad scanner, the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one active-low column at a time and samples the four active-low rows.
- Debounces full scan frames and reports each new key press as a 4-bit code through a one-deep valid/ack buffer.
- Sits between the board keypad pins and user logic; for example, a key code can feed a 4-bit digit of the display data word.

Parameters:
- SCAN_DIV_W, 15: scan-tick divider width. One tick every 2^SCAN_DIV_W clk cycles, about 3 kHz at 100 MHz.
- DEBOUNCE_FRAMES, 3: consecutive identical frames required before the debounced state updates. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- o_col  output  4  column drive, active-low, exactly one bit low
- i_row  input  4  row sense, active-low, pulled up on the board, asynchronous
- o_key_code  output  4  buffered key index = col*4 + row
- o_key_valid  output  1  buffered code pending; level, held until acknowledged
- i_key_ack  input  1  consumer acknowledge; only meaningful while o_key_valid=1
- o_overrun  output  1  sticky: a press was lost while a code was pending
- o_key_down  output  1  OR of the debounced bitmap
- o_key_bitmap  output  16  debounced key state; bit col*4+row is 1 when pressed

Behaviour:
Clocking and reset:
- Single clock domain. Reset is asynchronous, active-low, on rstn.
- Reset values: divider 0, col_addr 0, o_col=4'b1110, all raw, last-frame and debounced bitmaps 0, run count 0.
- Reset values of outputs: o_key_valid=0, o_key_code=0, o_overrun=0, o_key_down=0, o_key_bitmap=0.

Row sampling:
- i_row passes through a 2-flop synchronizer, reset value 4'hF.

Scan timing:
- Free-running divider cnt of SCAN_DIV_W bits.
- tick is a 1-clk pulse when cnt is all ones.
- o_col = ~(4'b0001 << col_addr), decoded combinationally from the col_addr register.
- On tick: store ~row_sync into the raw nibble for column col_addr, then col_addr <= col_addr+1, wrapping 3->0.
- Sampling happens at the end of each column period, so each column gets a full tick period to settle.

Frame debounce:
- A frame completes on the tick with col_addr==3.
- The frame value is the three stored nibbles plus the column-3 nibble sampled in that same cycle.
- If frame == last_frame: run <= min(run+1, DEBOUNCE_FRAMES). Otherwise: run <= 1 and last_frame <= frame.
- When the updated run reaches DEBOUNCE_FRAMES, o_key_bitmap <= frame on the next clk.

Press events:
- new = frame & ~o_key_bitmap, evaluated at the bitmap update.
- If new != 0, assert a 1-clk press event carrying the lowest set index.
- Other simultaneously new keys appear in o_key_bitmap but produce no event.
- Releases never produce events.

Output buffer FSM:
- IDLE (o_key_valid=0):
  - event -> latch code, o_key_valid=1, go to PENDING.
- PENDING (o_key_valid=1):
  - i_key_ack only -> o_key_valid=0, o_overrun=0, go to IDLE.
  - event and i_key_ack in the same cycle -> latch the new code, stay in PENDING, o_key_valid stays 1, o_overrun=0.
  - event without ack -> o_key_code unchanged, o_overrun=1.
- i_key_ack while in IDLE is ignored.

Latency:
- A press held stably produces o_key_valid within DEBOUNCE_FRAMES+1 frames, plus 3 clk after the row first reads low.

Reset mid-operation:
- Everything returns immediately to reset values. Any pending code is discarded.
- A key still held after reset is re-reported once it debounces.

Test Plan:
All scenarios use SCAN_DIV_W=4 (tick every 16 clk, frame 64 clk) and DEBOUNCE_FRAMES=3. A keypad model pulls i_row[r] low while o_col[c] is low and key (c,r) is held.

1. Single press: hold key (1,2) -> o_key_valid rises within 4 frames (<=259 clk), o_key_code=4'h6, o_key_bitmap=16'h0040, o_key_down=1. Pulse i_key_ack -> o_key_valid=0 next clk. Release -> bitmap 0 after 3 frames with no new valid.
2. Bounce: key (2,1) toggles every 40 clk for 300 clk, then held -> exactly one valid with code 4'h9. No valid occurs during the bounce window.
3. Overrun: press and hold (1,2), no ack; release; press (2,1) -> code stays 4'h6, o_overrun=1. Ack -> o_key_valid=0, o_overrun=0.
4. Ack collides with event: code 4'h6 pending; assert i_key_ack on the exact event clk for key (3,0) -> o_key_valid stays 1, o_key_code=4'hC, o_overrun=0.
5. Multi-key: keys (0,3) and (3,0) pressed within the same frame -> one valid with code 4'h3, o_key_bitmap=16'h1008.
6. Reset mid-pending: code pending, rstn low for 2 clk -> o_key_valid=0, o_col=4'b1110, o_key_bitmap=0, o_overrun=0. The still-held key is re-reported after debounce.
